// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem request handshake and the IF/ID register.
// A redirect that lands while a request is outstanding drains the stale response in DISCARD.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall_f,
  input  logic          stall_d,
  input  logic          flush_d,
  input  logic          pc_src_e,
  input  logic [31:0]   pc_target_e,
  fetch_stage_if.master imem,
  output logic [31:0]   instr_d,
  output logic [31:0]   pc_d,
  output logic [31:0]   pc_plus4_d,
  output logic          valid_d,
  output logic          fetch_busy
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic [31:0] hold_q, hold_d;

  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
  logic        if_valid_q, if_valid_d;

  logic [31:0] pc_plus4_f;
  logic [31:0] redirect_pc;
  logic        accept;
  logic        unused_target_lsbs;

  assign pc_plus4_f         = pc_f_q + 32'd4;
  assign redirect_pc        = {pc_target_e[31:2], 2'b00};
  assign unused_target_lsbs = ^pc_target_e[1:0];

  // req_q is low only in HOLD and in the partial cycle straight after reset,
  // so a ready pulse without an outstanding request is ignored.
  assign accept = (state_q == FETCH) && req_q && imem.ready;

  always_comb begin
    state_d = state_q;
    pc_f_d  = pc_f_q;
    hold_d  = hold_q;

    case (state_q)
      FETCH: begin
        if (pc_src_e) begin
          state_d = (req_q && !imem.ready) ? DISCARD : FETCH;
        end else if (accept && (stall_d || stall_f)) begin
          state_d = HOLD;
          hold_d  = imem.rdata;
        end else if (accept) begin
          pc_f_d = pc_plus4_f;
        end
      end
      HOLD: begin
        if (pc_src_e) begin
          state_d = FETCH;
          hold_d  = '0;
        end else if (!stall_d && !stall_f) begin
          state_d = FETCH;
          pc_f_d  = pc_plus4_f;
        end
      end
      DISCARD: begin
        if (imem.ready) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    if (pc_src_e) begin
      pc_f_d = redirect_pc;
    end

    // The stale request keeps its address until memory answers it.
    req_d  = (state_d != HOLD);
    addr_d = (state_d == DISCARD) ? addr_q : pc_f_d;
  end

  always_comb begin
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;
    if_valid_d    = if_valid_q;

    if (flush_d) begin
      if_instr_d = NOP_INSTR;
      if_valid_d = 1'b0;
    end else if (!stall_d) begin
      if_instr_d = NOP_INSTR;
      if_valid_d = 1'b0;
      if (!pc_src_e && !stall_f) begin
        if (accept) begin
          if_instr_d    = imem.rdata;
          if_pc_d       = pc_f_q;
          if_pc_plus4_d = pc_plus4_f;
          if_valid_d    = 1'b1;
        end else if (state_q == HOLD) begin
          if_instr_d    = hold_q;
          if_pc_d       = pc_f_q;
          if_pc_plus4_d = pc_plus4_f;
          if_valid_d    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_f_q        <= RESET_PC;
      addr_q        <= RESET_PC;
      req_q         <= 1'b0;
      hold_q        <= '0;
      if_instr_q    <= NOP_INSTR;
      if_pc_q       <= '0;
      if_pc_plus4_q <= '0;
      if_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_f_q        <= pc_f_d;
      addr_q        <= addr_d;
      req_q         <= req_d;
      hold_q        <= hold_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      if_valid_q    <= if_valid_d;
    end
  end

  assign imem.req   = req_q;
  assign imem.addr  = addr_q;
  assign fetch_busy = req_q && !imem.ready;

  assign instr_d    = if_instr_q;
  assign pc_d       = if_pc_q;
  assign pc_plus4_d = if_pc_plus4_q;
  assign valid_d    = if_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the bench plays the instruction memory and
// checks the IF/ID register, request bus and busy flag against hand-computed values.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        fetch_busy;

  int vectors     = 0;
  int miscompares = 0;

  fetch_stage_if imem_bus ();

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .pc_src_e    (pc_src_e),
    .pc_target_e (pc_target_e),
    .imem        (imem_bus),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d),
    .fetch_busy  (fetch_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic sf, input logic sd, input logic fd,
                                input logic src, input logic [31:0] target,
                                input logic rdy, input logic [31:0] rdata);
    stall_f        = sf;
    stall_d        = sd;
    flush_d        = fd;
    pc_src_e       = src;
    pc_target_e    = target;
    imem_bus.ready = rdy;
    imem_bus.rdata = rdata;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc, input logic [31:0] pc4,
                            input logic valid);
    check_output({tag, ".instr_d"}, instr_d, instr);
    check_output({tag, ".pc_d"}, pc_d, pc);
    check_output({tag, ".pc_plus4_d"}, pc_plus4_d, pc4);
    check_output({tag, ".valid_d"}, {31'd0, valid_d}, {31'd0, valid});
  endtask

  initial begin
    reset = 1'b1;
    apply_stimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
    #2;
    check_output("rst.req", {31'd0, imem_bus.req}, 32'd0);
    check_output("rst.addr", imem_bus.addr, 32'h0);
    check_output("rst.busy", {31'd0, fetch_busy}, 32'd0);
    check_ifid("rst", NOP, 32'h0, 32'h0, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check_output("first.req", {31'd0, imem_bus.req}, 32'd1);
    check_output("first.addr", imem_bus.addr, 32'h0);

    // Zero-wait stream A, B, C
    apply_stimulus(0, 0, 0, 0, 32'h0, 1, 32'hAAAA_0001);
    #1;
    check_output("stream.busy", {31'd0, fetch_busy}, 32'd0);
    tick();
    check_ifid("streamA", 32'hAAAA_0001, 32'h0, 32'h4, 1'b1);
    check_output("streamA.addr", imem_bus.addr, 32'h4);
    apply_stimulus(0, 0, 0, 0, 32'h0, 1, 32'hBBBB_0002);
    tick();
    check_ifid("streamB", 32'hBBBB_0002, 32'h4, 32'h8, 1'b1);
    apply_stimulus(0, 0, 0, 0, 32'h0, 1, 32'hCCCC_0003);
    tick();
    check_ifid("streamC", 32'hCCCC_0003, 32'h8, 32'hC, 1'b1);
    check_output("streamC.addr", imem_bus.addr, 32'hC);

    // Two wait states at 0xC
    apply_stimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
    #1;
    check_output("wait0.busy", {31'd0, fetch_busy}, 32'd1);
    tick();
    check_ifid("wait1", NOP, 32'h8, 32'hC, 1'b0);
    check_output("wait1.addr", imem_bus.addr, 32'hC);
    check_output("wait1.busy", {31'd0, fetch_busy}, 32'd1);
    tick();
    check_ifid("wait2", NOP, 32'h8, 32'hC, 1'b0);
    apply_stimulus(0, 0, 0, 0, 32'h0, 1, 32'hDDDD_0004);
    #1;
    check_output("wait.done.busy", {31'd0, fetch_busy}, 32'd0);
    tick();
    check_ifid("waitD", 32'hDDDD_0004, 32'hC, 32'h10, 1'b1);
    check_output("waitD.addr", imem_bus.addr, 32'h10);

    // Stall for three cycles with the response arriving in the first
    apply_stimulus(1, 1, 0, 0, 32'h0, 1, 32'hEEEE_0005);
    tick();
    check_output("hold1.req", {31'd0, imem_bus.req}, 32'd0);
    check_ifid("hold1", 32'hDDDD_0004, 32'hC, 32'h10, 1'b1);
    apply_stimulus(1, 1, 0, 0, 32'h0, 0, 32'h0);
    #1;
    check_output("hold1.busy", {31'd0, fetch_busy}, 32'd0);
    tick();
    check_output("hold2.req", {31'd0, imem_bus.req}, 32'd0);
    check_output("hold2.instr", instr_d, 32'hDDDD_0004);
    tick();
    check_output("hold3.req", {31'd0, imem_bus.req}, 32'd0);
    apply_stimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
    tick();
    check_ifid("holdE", 32'hEEEE_0005, 32'h10, 32'h14, 1'b1);
    check_output("holdE.req", {31'd0, imem_bus.req}, 32'd1);
    check_output("holdE.addr", imem_bus.addr, 32'h14);

    // Redirect to 0x103 during a wait state
    apply_stimulus(0, 0, 0, 1, 32'h0000_0103, 0, 32'h0);
    #1;
    check_output("disc0.busy", {31'd0, fetch_busy}, 32'd1);
    tick();
    check_ifid("disc1", NOP, 32'h10, 32'h14, 1'b0);
    check_output("disc1.req", {31'd0, imem_bus.req}, 32'd1);
    check_output("disc1.addr", imem_bus.addr, 32'h14);
    apply_stimulus(0, 0, 0, 0, 32'h0, 1, 32'hBAD0_0001);
    tick();
    check_ifid("disc2", NOP, 32'h10, 32'h14, 1'b0);
    check_output("disc2.addr", imem_bus.addr, 32'h100);
    apply_stimulus(0, 0, 0, 0, 32'h0, 1, 32'hFFFF_0006);
    tick();
    check_ifid("discF", 32'hFFFF_0006, 32'h100, 32'h104, 1'b1);
    check_output("discF.addr", imem_bus.addr, 32'h104);

    // Flush and stall together
    apply_stimulus(0, 1, 1, 0, 32'h0, 0, 32'h0);
    tick();
    check_output("flush.instr", instr_d, NOP);
    check_output("flush.valid", {31'd0, valid_d}, 32'd0);
    check_output("flush.addr", imem_bus.addr, 32'h104);

    // Reset while a request to 0x104 is outstanding
    apply_stimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
    reset = 1'b1;
    #1;
    check_output("rst2.req", {31'd0, imem_bus.req}, 32'd0);
    check_output("rst2.addr", imem_bus.addr, 32'h0);
    check_output("rst2.busy", {31'd0, fetch_busy}, 32'd0);
    check_ifid("rst2", NOP, 32'h0, 32'h0, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check_output("rst2.first.req", {31'd0, imem_bus.req}, 32'd1);
    check_output("rst2.first.addr", imem_bus.addr, 32'h0);
    apply_stimulus(0, 0, 0, 0, 32'h0, 1, 32'h1111_0007);
    tick();
    check_ifid("late", 32'h1111_0007, 32'h0, 32'h4, 1'b1);
    check_output("late.addr", imem_bus.addr, 32'h4);

    // Redirect with a same-cycle response, then PC wrap-around
    apply_stimulus(0, 0, 0, 1, 32'hFFFF_FFFE, 1, 32'hBAD0_0002);
    tick();
    check_output("wrap0.instr", instr_d, NOP);
    check_output("wrap0.valid", {31'd0, valid_d}, 32'd0);
    check_output("wrap0.addr", imem_bus.addr, 32'hFFFF_FFFC);
    apply_stimulus(0, 0, 0, 0, 32'h0, 1, 32'h2222_0008);
    tick();
    check_ifid("wrapG", 32'h2222_0008, 32'hFFFF_FFFC, 32'h0, 1'b1);
    check_output("wrapG.addr", imem_bus.addr, 32'h0);

    // Second redirect while draining a stale response
    apply_stimulus(0, 0, 0, 1, 32'h0000_0040, 0, 32'h0);
    tick();
    check_output("dbl1.addr", imem_bus.addr, 32'h0);
    check_output("dbl1.req", {31'd0, imem_bus.req}, 32'd1);
    apply_stimulus(0, 0, 0, 1, 32'h0000_0080, 0, 32'h0);
    tick();
    check_output("dbl2.addr", imem_bus.addr, 32'h0);
    check_output("dbl2.busy", {31'd0, fetch_busy}, 32'd1);
    apply_stimulus(0, 0, 0, 0, 32'h0, 1, 32'hBAD0_0003);
    tick();
    check_output("dbl3.addr", imem_bus.addr, 32'h80);
    check_output("dbl3.valid", {31'd0, valid_d}, 32'd0);
    apply_stimulus(0, 0, 0, 0, 32'h0, 1, 32'h3333_0009);
    tick();
    check_ifid("dblJ", 32'h3333_0009, 32'h80, 32'h84, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
